// File: rtl/mem_access.sv
// Memory-access pipeline stage: samples execute-stage results, performs the data-memory
// load/store over a req/ack handshake, stalls upstream while waiting, and feeds writeback.
module mem_access #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16,
    parameter int IALU_WORD_WIDTH = 16,
    parameter int PC_WIDTH        = 12,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic                       in_act_write_res_to_reg,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
    input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic [IALU_WORD_WIDTH-1:0] in_res,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic                       in_dmem_ack,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_rdata,
    output logic                       out_dmem_req,
    output logic                       out_dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_dmem_wdata,
    output logic                       out_stall,
    output logic                       out_act_write_res_to_reg,
    output logic [IALU_WORD_WIDTH-1:0] out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic [PMEM_WORD_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [STALL_CNT_WIDTH-1:0] out_stall_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t state;

    logic                       s_load;
    logic                       s_store;
    logic                       s_wen;
    logic [DMEM_ADDR_WIDTH-1:0] s_rd_addr;
    logic [DMEM_ADDR_WIDTH-1:0] s_wr_addr;
    logic [DMEM_WORD_WIDTH-1:0] s_wr_word;
    logic [PMEM_WORD_WIDTH-1:0] s_instr;
    logic [PC_WIDTH-1:0]        s_pc;
    logic [IALU_WORD_WIDTH-1:0] s_res;
    logic [REG_IDX_WIDTH-1:0]   s_res_reg_idx;

    logic mem_op;
    logic is_store;
    logic is_load;
    logic op_done;

    // A simultaneous load+store resolves to the store; the load is dropped.
    assign mem_op   = s_load | s_store;
    assign is_store = s_store;
    assign is_load  = s_load & ~s_store;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values and block ordering cannot change behaviour.
    always_ff @(posedge clock) begin
        if (reset) begin
            s_load        <= 1'b0;
            s_store       <= 1'b0;
            s_wen         <= 1'b0;
            s_rd_addr     <= '0;
            s_wr_addr     <= '0;
            s_wr_word     <= '0;
            s_instr       <= '0;
            s_pc          <= '0;
            s_res         <= '0;
            s_res_reg_idx <= '0;
        end else if (!out_stall) begin
            s_load        <= in_act_load_dmem;
            s_store       <= in_act_store_dmem;
            s_wen         <= in_act_write_res_to_reg;
            s_rd_addr     <= in_dmem_rd_addr;
            s_wr_addr     <= in_dmem_wr_addr;
            s_wr_word     <= in_dmem_wr_word;
            s_instr       <= in_instr;
            s_pc          <= in_pc;
            s_res         <= in_res;
            s_res_reg_idx <= in_res_reg_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (mem_op && !in_dmem_ack) state <= ST_WAIT;
                ST_WAIT: if (in_dmem_ack) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        out_stall = 1'b0;
        op_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                out_stall = mem_op & ~in_dmem_ack;
                op_done   = ~mem_op | in_dmem_ack;
            end
            ST_WAIT: begin
                out_stall = ~in_dmem_ack;
                op_done   = in_dmem_ack;
            end
            default: begin
                out_stall = 1'b0;
                op_done   = 1'b0;
            end
        endcase
    end

    // Request fields come straight from the sampled registers, which are frozen while
    // stalled, so they stay constant for the whole access.
    always_comb begin
        out_dmem_req   = mem_op;
        out_dmem_we    = is_store;
        out_dmem_addr  = '0;
        out_dmem_wdata = '0;
        if (is_store) begin
            out_dmem_addr  = s_wr_addr;
            out_dmem_wdata = s_wr_word;
        end else if (is_load) begin
            out_dmem_addr  = s_rd_addr;
        end
    end

    always_comb begin
        out_act_write_res_to_reg = s_wen & op_done;
        out_res                  = (is_load && in_dmem_ack) ? in_dmem_rdata : s_res;
        out_res_reg_idx          = '0;
        out_instr                = '0;
        out_pc                   = '0;
        if (op_done) begin
            out_res_reg_idx = s_res_reg_idx;
            out_instr       = s_instr;
            out_pc          = s_pc;
        end
    end

    // Saturating stall-cycle counter: holds at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_stall_cnt <= '0;
        end else if (out_stall && (out_stall_cnt != {STALL_CNT_WIDTH{1'b1}})) begin
            out_stall_cnt <= out_stall_cnt + 1'b1;
        end
    end

endmodule
